// File: rtl/pong_pkg.sv
// Shared encodings for the Pong controller: game states, custom-instruction
// opcodes, status codes and power-on colour masks.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [3:0] OP_READ   = 4'd0;
    localparam logic [3:0] OP_PADDLE = 4'd1;
    localparam logic [3:0] OP_START  = 4'd2;
    localparam logic [3:0] OP_PAUSE  = 4'd3;
    localparam logic [3:0] OP_COLOUR = 4'd4;

    localparam logic [31:0] RESULT_BAD_OP = 32'hFFFF_FFFF;
    localparam logic [31:0] RESULT_REJECT = 32'h0000_0001;

    // Per-channel {R,G,B} masks, replicated to COLOR_W bits by the controller.
    localparam logic [2:0] FG_RESET_MASK = 3'b101;
    localparam logic [2:0] BG_RESET_MASK = 3'b001;

    function automatic logic [3:0] status_code(input state_e s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/pong_ci_decode.sv
// Custom-instruction front end: start/done handshake, opcode strobes and the
// registered result mux. A command executes on the edge that accepts it.
module pong_ci_decode
    import pong_pkg::*;
#(
    parameter int Y_W = 9
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clk_en_i,
    input  logic           start_i,
    input  logic [3:0]     opcode_i,
    input  logic [3:0]     status_i,
    input  logic [19:0]    scores_i,
    input  logic           paddle_ok_i,
    input  logic [Y_W-1:0] paddle_y_i,
    output logic           fire_paddle_o,
    output logic           fire_start_o,
    output logic           fire_pause_o,
    output logic           fire_colour_o,
    output logic [31:0]    result_o,
    output logic           done_o
);

    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        fire;

    // The cycle in which done is high counts as pending, so a start held
    // across it is not taken as a second command.
    assign fire = start_i & clk_en_i & ~done_q;

    assign fire_paddle_o = fire && (opcode_i == OP_PADDLE);
    assign fire_start_o  = fire && (opcode_i == OP_START);
    assign fire_pause_o  = fire && (opcode_i == OP_PAUSE);
    assign fire_colour_o = fire && (opcode_i == OP_COLOUR);

    always_comb begin
        done_d   = fire;
        result_d = result_q;
        if (fire) begin
            case (opcode_i)
                OP_READ:   result_d = {status_i, 8'b0, scores_i};
                OP_PADDLE: result_d = paddle_ok_i ? {{(32-Y_W){1'b0}}, paddle_y_i}
                                                  : RESULT_REJECT;
                OP_START,
                OP_PAUSE,
                OP_COLOUR: result_d = 32'h0;
                default:   result_d = RESULT_BAD_OP;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q   <= 1'b0;
            result_q <= 32'h0;
        end else begin
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong controller: game-state FSM, two-player scoring, clamped paddle
// registers and the registered VGA colour mux, driven by custom instructions.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int N_PADDLES = 2,
    parameter int Y_W       = 9,
    parameter int Y_MAX     = 479,
    parameter int PADDLE_H  = 60,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 3,
    parameter int SERVE_FR  = 60,
    parameter int N_LAYERS  = 4,
    parameter int COLOR_W   = 1
) (
    input  logic                     CLK,
    input  logic                     resentinho,
    input  logic                     clk_en,
    input  logic                     start,
    input  logic [31:0]              dataa,
    input  logic [31:0]              datab,
    output logic [31:0]              result,
    output logic                     done,
    input  logic                     pix_stb,
    input  logic                     frame_tick,
    input  logic                     active,
    input  logic [N_LAYERS-1:0]      layer_hit,
    input  logic                     miss_l,
    input  logic                     miss_r,
    output logic [N_PADDLES*Y_W-1:0] paddle_y,
    output logic [N_PADDLES-1:0]     paddle_upd,
    output logic                     game_en,
    output logic                     ball_run,
    output logic [COLOR_W-1:0]       vga_r,
    output logic [COLOR_W-1:0]       vga_g,
    output logic [COLOR_W-1:0]       vga_b
);

    localparam int               CNT_W   = $clog2(SERVE_FR + 1);
    localparam int               CW3     = 3 * COLOR_W;
    localparam int               SC_PAD  = 20 - 2 * SCORE_W;
    localparam logic [Y_W-1:0]   Y_LIMIT = Y_W'(Y_MAX + 1 - PADDLE_H);
    localparam logic [Y_W-1:0]   Y_RESET = Y_W'((Y_MAX + 1 - PADDLE_H) / 2);
    localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
    localparam logic [CW3-1:0]   FG_RESET = {{COLOR_W{FG_RESET_MASK[2]}},
                                             {COLOR_W{FG_RESET_MASK[1]}},
                                             {COLOR_W{FG_RESET_MASK[0]}}};
    localparam logic [CW3-1:0]   BG_RESET = {{COLOR_W{BG_RESET_MASK[2]}},
                                             {COLOR_W{BG_RESET_MASK[1]}},
                                             {COLOR_W{BG_RESET_MASK[0]}}};

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? WIN : s + SCORE_W'(1);
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     serve_cnt_q, serve_cnt_d;
    logic [SCORE_W-1:0]   score0_q, score0_d, score1_q, score1_d;
    logic [Y_W-1:0]       pad_q [N_PADDLES];
    logic [N_PADDLES-1:0] upd_q, upd_d;
    logic [CW3-1:0]       fg_q, fg_d, bg_q, bg_d, pix_q, pix_d;

    logic           fire_paddle, fire_start, fire_pause, fire_colour;
    logic [3:0]     paddle_idx;
    logic [Y_W-1:0] paddle_raw, paddle_clamp;
    logic           paddle_ok;
    logic           layer_any;
    logic           unused_bits;

    assign unused_bits = ^{dataa, datab};

    assign paddle_idx   = dataa[27:24];
    assign paddle_raw   = dataa[Y_W-1:0];
    assign paddle_clamp = (paddle_raw > Y_LIMIT) ? Y_LIMIT : paddle_raw;
    assign paddle_ok    = (paddle_idx < 4'(N_PADDLES)) &&
                          (state_q == ST_SERVE || state_q == ST_PLAY);

    pong_ci_decode #(
        .Y_W (Y_W)
    ) u_decode (
        .clk_i         (CLK),
        .rst_ni        (resentinho),
        .clk_en_i      (clk_en),
        .start_i       (start),
        .opcode_i      (dataa[31:28]),
        .status_i      (status_code(state_q)),
        .scores_i      ({{SC_PAD{1'b0}}, score1_q, score0_q}),
        .paddle_ok_i   (paddle_ok),
        .paddle_y_i    (paddle_clamp),
        .fire_paddle_o (fire_paddle),
        .fire_start_o  (fire_start),
        .fire_pause_o  (fire_pause),
        .fire_colour_o (fire_colour),
        .result_o      (result),
        .done_o        (done)
    );

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        score0_d    = score0_q;
        score1_d    = score1_q;
        case (state_q)
            ST_MENU, ST_OVER: begin
                if (fire_start) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = '0;
                    score0_d    = '0;
                    score1_d    = '0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt_q == CNT_W'(SERVE_FR - 1)) begin
                        state_d     = ST_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                // A miss outranks a pause command arriving in the same cycle;
                // a simultaneous double miss is a void rally.
                if (miss_l || miss_r) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = '0;
                    if (miss_r && !miss_l) begin
                        score0_d = sat_inc(score0_q);
                        if (score0_d == WIN) state_d = ST_OVER;
                    end else if (miss_l && !miss_r) begin
                        score1_d = sat_inc(score1_q);
                        if (score1_d == WIN) state_d = ST_OVER;
                    end
                end else if (fire_pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (fire_pause) state_d = ST_PLAY;
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_comb begin
        upd_d = '0;
        if (fire_paddle && paddle_ok) upd_d = N_PADDLES'(1) << paddle_idx;
    end

    // The menu layer only shows on the menu and game-over screens.
    assign layer_any = (|layer_hit[N_LAYERS-1:1]) ||
                       (layer_hit[0] && (state_q == ST_MENU || state_q == ST_OVER));

    always_comb begin
        fg_d  = fg_q;
        bg_d  = bg_q;
        pix_d = pix_q;
        if (fire_colour) begin
            fg_d = datab[CW3-1:0];
            bg_d = datab[16 +: CW3];
        end
        if (pix_stb) begin
            if (!active)        pix_d = '0;
            else if (layer_any) pix_d = fg_q;
            else                pix_d = bg_q;
        end
    end

    always_ff @(posedge CLK or negedge resentinho) begin
        if (!resentinho) begin
            state_q     <= ST_MENU;
            serve_cnt_q <= '0;
            score0_q    <= '0;
            score1_q    <= '0;
            upd_q       <= '0;
            fg_q        <= FG_RESET;
            bg_q        <= BG_RESET;
            pix_q       <= '0;
            for (int i = 0; i < N_PADDLES; i++) pad_q[i] <= Y_RESET;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            score0_q    <= score0_d;
            score1_q    <= score1_d;
            upd_q       <= upd_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            pix_q       <= pix_d;
            for (int i = 0; i < N_PADDLES; i++) begin
                if (upd_d[i]) pad_q[i] <= paddle_clamp;
            end
        end
    end

    for (genvar g = 0; g < N_PADDLES; g++) begin : g_pad_out
        assign paddle_y[g*Y_W +: Y_W] = pad_q[g];
    end

    assign paddle_upd = upd_q;
    assign game_en    = (state_q == ST_SERVE) || (state_q == ST_PLAY);
    assign ball_run   = (state_q == ST_PLAY);
    assign vga_r      = pix_q[2*COLOR_W +: COLOR_W];
    assign vga_g      = pix_q[COLOR_W +: COLOR_W];
    assign vga_b      = pix_q[0 +: COLOR_W];

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with default parameters.
module tb_pong_game_ctrl;

    logic        CLK = 1'b0;
    logic        resentinho = 1'b0;
    logic        clk_en = 1'b0, start = 1'b0;
    logic [31:0] dataa = '0, datab = '0;
    logic [31:0] result;
    logic        done;
    logic        pix_stb = 1'b0, frame_tick = 1'b0, active = 1'b0;
    logic [3:0]  layer_hit = '0;
    logic        miss_l = 1'b0, miss_r = 1'b0;
    logic [17:0] paddle_y;
    logic [1:0]  paddle_upd;
    logic        game_en, ball_run;
    logic        vga_r, vga_g, vga_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] r_res;
    logic        r_done;
    logic [1:0]  r_upd;

    always #5 CLK = ~CLK;

    pong_game_ctrl dut (
        .CLK        (CLK),
        .resentinho (resentinho),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .result     (result),
        .done       (done),
        .pix_stb    (pix_stb),
        .frame_tick (frame_tick),
        .active     (active),
        .layer_hit  (layer_hit),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .paddle_y   (paddle_y),
        .paddle_upd (paddle_upd),
        .game_en    (game_en),
        .ball_run   (ball_run),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        dataa = a; datab = b; start = 1'b1; clk_en = 1'b1;
        @(negedge CLK);
        start = 1'b0; clk_en = 1'b0;
        r_done = done; r_res = result; r_upd = paddle_upd;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge CLK); frame_tick = 1'b1;
            @(negedge CLK); frame_tick = 1'b0;
        end
    endtask

    task automatic miss(input logic l, input logic r);
        @(negedge CLK); miss_l = l; miss_r = r;
        @(negedge CLK); miss_l = 1'b0; miss_r = 1'b0;
    endtask

    task automatic pixel(input logic act, input logic [3:0] hit);
        @(negedge CLK); active = act; layer_hit = hit; pix_stb = 1'b1;
        @(negedge CLK); pix_stb = 1'b0;
    endtask

    task automatic test_reset();
        resentinho = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (done !== 1'b0 || result !== 32'h0 || paddle_upd !== 2'b00) begin
            errors++;
            $display("FAIL reset_ci done=%0b result=%h upd=%b want 0/00000000/00", done, result, paddle_upd);
        end
        checks++;
        if (paddle_y !== {9'd210, 9'd210}) begin
            errors++;
            $display("FAIL reset_paddles got %0d,%0d want 210,210", paddle_y[8:0], paddle_y[17:9]);
        end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b000 || game_en !== 1'b0 || ball_run !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs vga=%b game_en=%b ball_run=%b want 000/0/0", {vga_r, vga_g, vga_b}, game_en, ball_run);
        end
        @(negedge CLK); resentinho = 1'b1;
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_done !== 1'b1 || r_res !== 32'h0) begin
            errors++;
            $display("FAIL read_menu done=%0b result=%h want 1/00000000", r_done, r_res);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle done=%0b want 0", done);
        end
        pixel(1'b1, 4'b0000);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b001) begin
            errors++;
            $display("FAIL default_bg vga=%b want 001", {vga_r, vga_g, vga_b});
        end
        pixel(1'b1, 4'b0001);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b101) begin
            errors++;
            $display("FAIL menu_layer_fg vga=%b want 101", {vga_r, vga_g, vga_b});
        end
        issue(32'h1000_0005, 32'h0);
        checks++;
        if (r_res !== 32'h1 || r_upd !== 2'b00) begin
            errors++;
            $display("FAIL paddle_in_menu result=%h upd=%b want 00000001/00", r_res, r_upd);
        end
        issue(32'hF000_0000, 32'h0);
        checks++;
        if (r_done !== 1'b1 || r_res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL bad_opcode done=%0b result=%h want 1/ffffffff", r_done, r_res);
        end
    endtask

    task automatic test_serve_play();
        issue(32'h2000_0000, 32'h0);
        checks++;
        if (r_done !== 1'b1 || game_en !== 1'b1 || ball_run !== 1'b0) begin
            errors++;
            $display("FAIL start_serve done=%0b game_en=%b ball_run=%b want 1/1/0", r_done, game_en, ball_run);
        end
        ticks(59);
        checks++;
        if (ball_run !== 1'b0) begin
            errors++;
            $display("FAIL serve_59 ball_run=%b want 0", ball_run);
        end
        ticks(1);
        checks++;
        if (ball_run !== 1'b1 || game_en !== 1'b1) begin
            errors++;
            $display("FAIL serve_60 ball_run=%b game_en=%b want 1/1", ball_run, game_en);
        end
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h2000_0000) begin
            errors++;
            $display("FAIL read_play result=%h want 20000000", r_res);
        end
    endtask

    task automatic test_paddle();
        issue(32'h1100_01F4, 32'h0);
        checks++;
        if (r_res !== 32'd420 || r_upd !== 2'b10) begin
            errors++;
            $display("FAIL paddle_clamp result=%0d upd=%b want 420/10", r_res, r_upd);
        end
        checks++;
        if (paddle_y !== {9'd420, 9'd210}) begin
            errors++;
            $display("FAIL paddle_regs got %0d,%0d want 210,420", paddle_y[8:0], paddle_y[17:9]);
        end
        @(negedge CLK);
        checks++;
        if (paddle_upd !== 2'b00) begin
            errors++;
            $display("FAIL upd_pulse upd=%b want 00", paddle_upd);
        end
        issue(32'h1000_0064, 32'h0);
        checks++;
        if (r_res !== 32'd100 || r_upd !== 2'b01 || paddle_y[8:0] !== 9'd100) begin
            errors++;
            $display("FAIL paddle0 result=%0d upd=%b y0=%0d want 100/01/100", r_res, r_upd, paddle_y[8:0]);
        end
        issue(32'h1500_0010, 32'h0);
        checks++;
        if (r_res !== 32'h1 || r_upd !== 2'b00 || paddle_y !== {9'd420, 9'd100}) begin
            errors++;
            $display("FAIL paddle_bad_idx result=%h upd=%b y=%h want 00000001/00/%h", r_res, r_upd, paddle_y, {9'd420, 9'd100});
        end
    endtask

    task automatic test_pause();
        issue(32'h3000_0000, 32'h0);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h3000_0000 || ball_run !== 1'b0 || game_en !== 1'b0) begin
            errors++;
            $display("FAIL pause result=%h ball_run=%b game_en=%b want 30000000/0/0", r_res, ball_run, game_en);
        end
        miss(1'b0, 1'b1);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h3000_0000) begin
            errors++;
            $display("FAIL miss_in_pause result=%h want 30000000", r_res);
        end
        issue(32'h3000_0000, 32'h0);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h2000_0000 || ball_run !== 1'b1) begin
            errors++;
            $display("FAIL resume result=%h ball_run=%b want 20000000/1", r_res, ball_run);
        end
    endtask

    task automatic test_scoring();
        miss(1'b0, 1'b1);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h1000_0001) begin
            errors++;
            $display("FAIL score_r1 result=%h want 10000001", r_res);
        end
        miss(1'b0, 1'b1);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h1000_0001) begin
            errors++;
            $display("FAIL miss_in_serve result=%h want 10000001", r_res);
        end
        ticks(60);
        miss(1'b0, 1'b1);
        ticks(60);
        miss(1'b1, 1'b0);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h1000_0012) begin
            errors++;
            $display("FAIL score_mix result=%h want 10000012", r_res);
        end
        ticks(60);
        miss(1'b1, 1'b1);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h1000_0012 || game_en !== 1'b1 || ball_run !== 1'b0) begin
            errors++;
            $display("FAIL double_miss result=%h game_en=%b ball_run=%b want 10000012/1/0", r_res, game_en, ball_run);
        end
        ticks(60);
        miss(1'b0, 1'b1);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h4000_0013 || game_en !== 1'b0) begin
            errors++;
            $display("FAIL game_over result=%h game_en=%b want 40000013/0", r_res, game_en);
        end
        miss(1'b0, 1'b1);
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_res !== 32'h4000_0013) begin
            errors++;
            $display("FAIL miss_in_over result=%h want 40000013", r_res);
        end
        issue(32'h1000_0020, 32'h0);
        checks++;
        if (r_res !== 32'h1 || r_upd !== 2'b00) begin
            errors++;
            $display("FAIL paddle_in_over result=%h upd=%b want 00000001/00", r_res, r_upd);
        end
    endtask

    task automatic test_colour();
        issue(32'h4000_0000, 32'h0004_0002);
        checks++;
        if (r_done !== 1'b1 || {vga_r, vga_g, vga_b} !== 3'b101) begin
            errors++;
            $display("FAIL colour_cmd done=%0b vga=%b want 1/101", r_done, {vga_r, vga_g, vga_b});
        end
        pixel(1'b1, 4'b0100);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b010) begin
            errors++;
            $display("FAIL fg_ball vga=%b want 010", {vga_r, vga_g, vga_b});
        end
        @(negedge CLK); active = 1'b0;
        @(negedge CLK);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b010) begin
            errors++;
            $display("FAIL hold_no_stb vga=%b want 010", {vga_r, vga_g, vga_b});
        end
        pixel(1'b0, 4'b0100);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b000) begin
            errors++;
            $display("FAIL blank vga=%b want 000", {vga_r, vga_g, vga_b});
        end
        pixel(1'b1, 4'b0000);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b100) begin
            errors++;
            $display("FAIL new_bg vga=%b want 100", {vga_r, vga_g, vga_b});
        end
        pixel(1'b1, 4'b0001);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b010) begin
            errors++;
            $display("FAIL menu_layer_over vga=%b want 010", {vga_r, vga_g, vga_b});
        end
        issue(32'h2000_0000, 32'h0);
        pixel(1'b1, 4'b0001);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 3'b100 || game_en !== 1'b1) begin
            errors++;
            $display("FAIL menu_layer_serve vga=%b game_en=%b want 100/1", {vga_r, vga_g, vga_b}, game_en);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        dataa = 32'h1000_0007; start = 1'b1; clk_en = 1'b1;
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || result !== 32'd7) begin
            errors++;
            $display("FAIL b2b_first done=%0b result=%h want 1/00000007", done, result);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pending_ignored done=%0b want 0", done);
        end
        start = 1'b1; clk_en = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL clk_en_gate done=%0b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        dataa = 32'h0000_0000; start = 1'b1; clk_en = 1'b1;
        @(posedge CLK);
        #1 resentinho = 1'b0; start = 1'b0; clk_en = 1'b0;
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || {vga_r, vga_g, vga_b} !== 3'b000 || paddle_y !== {9'd210, 9'd210}) begin
            errors++;
            $display("FAIL reset_mid done=%0b vga=%b y=%h want 0/000/%h", done, {vga_r, vga_g, vga_b}, paddle_y, {9'd210, 9'd210});
        end
        @(negedge CLK); resentinho = 1'b1;
        issue(32'h0000_0000, 32'h0);
        checks++;
        if (r_done !== 1'b1 || r_res !== 32'h0) begin
            errors++;
            $display("FAIL read_after_reset done=%0b result=%h want 1/00000000", r_done, r_res);
        end
    endtask

    initial begin
        test_reset();
        test_serve_play();
        test_paddle();
        test_pause();
        test_scoring();
        test_colour();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
